// File: rtl/multiway_data_array_if.sv
// Request/response bundle for the multi-way cache data array: flush, byte-enabled
// write port, one-way registered read port and the ready/valid status outputs.
interface multiway_data_array_if #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_way    = 2
);
  localparam int s_mask = 2**s_offset;
  localparam int s_line = 8*s_mask;

  logic                flush;
  logic                ready;
  logic                rd_req;
  logic [s_index-1:0]  rd_index;
  logic [s_way-1:0]    rd_way;
  logic [s_mask-1:0]   wr_en;
  logic [s_index-1:0]  wr_index;
  logic [s_way-1:0]    wr_way;
  logic [s_line-1:0]   datain;
  logic                rd_valid;
  logic [s_line-1:0]   dataout;

  modport master (
    output flush, rd_req, rd_index, rd_way, wr_en, wr_index, wr_way, datain,
    input  ready, rd_valid, dataout
  );

  modport slave (
    input  flush, rd_req, rd_index, rd_way, wr_en, wr_index, wr_way, datain,
    output ready, rd_valid, dataout
  );
endinterface

// File: rtl/multiway_data_array.sv
// Multi-way cache data store: num_ways x num_sets lines, per-byte writes, 1-cycle read,
// sequential clear after reset/flush. Define MULTIWAY_DATA_ARRAY_BYPASS_EN for write-first collisions.

module multiway_data_array_way #(
  parameter int s_offset = 5,
  parameter int s_index  = 3
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [s_index-1:0]     clr_set,
  input  logic [2**s_offset-1:0] wr_be,
  input  logic [s_index-1:0]     wr_set,
  input  logic [8*(2**s_offset)-1:0] wdata,
  input  logic [s_index-1:0]     rd_set,
  output logic [8*(2**s_offset)-1:0] rd_line
);
  localparam int s_mask   = 2**s_offset;
  localparam int s_line   = 8*s_mask;
  localparam int num_sets = 2**s_index;

  logic [s_line-1:0] mem [num_sets];

  // Storage is deliberately unreset; the clear sweep owns initialisation.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem[clr_set] <= '0;
    end else begin
      for (int b = 0; b < s_mask; b++) begin
        if (wr_be[b]) mem[wr_set][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rd_line = mem[rd_set];
endmodule

module multiway_data_array #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_way    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  multiway_data_array_if.slave  bus
);
  localparam int s_mask   = 2**s_offset;
  localparam int s_line   = 8*s_mask;
  localparam int num_sets = 2**s_index;
  localparam int num_ways = 2**s_way;
  localparam int cnt_w    = s_index + 1;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [cnt_w-1:0]  clr_cnt_q, clr_cnt_d;
  logic              clr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // A flush in either state restarts the sweep from set 0 on that edge.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (bus.flush) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == cnt_w'(num_sets-1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign bus.ready = (state_q == IDLE);

  logic accept, rd_fire, wr_fire;
  assign accept  = (state_q == IDLE) && !bus.flush;
  assign rd_fire = accept && bus.rd_req;
  assign wr_fire = accept && (|bus.wr_en);

  logic [num_ways-1:0][s_line-1:0] way_line;

  for (genvar w = 0; w < num_ways; w++) begin : g_way
    logic [s_mask-1:0] be;
    assign be = (wr_fire && bus.wr_way == s_way'(w)) ? bus.wr_en : '0;

    multiway_data_array_way #(
      .s_offset (s_offset),
      .s_index  (s_index)
    ) u_way (
      .clk     (clk),
      .clr     (clr_en),
      .clr_set (clr_cnt_q[s_index-1:0]),
      .wr_be   (be),
      .wr_set  (bus.wr_index),
      .wdata   (bus.datain),
      .rd_set  (bus.rd_index),
      .rd_line (way_line[w])
    );
  end

  logic [s_line-1:0] rd_line, rd_data;
  assign rd_line = way_line[bus.rd_way];

`ifdef MULTIWAY_DATA_ARRAY_BYPASS_EN
  // Write-first: forward enabled bytes of the same-cycle write into the read result.
  logic collide;
  assign collide = wr_fire && rd_fire &&
                   (bus.wr_index == bus.rd_index) && (bus.wr_way == bus.rd_way);

  always_comb begin
    rd_data = rd_line;
    for (int b = 0; b < s_mask; b++) begin
      if (collide && bus.wr_en[b]) rd_data[8*b +: 8] = bus.datain[8*b +: 8];
    end
  end
`else
  assign rd_data = rd_line;
`endif

  logic              rd_valid_q;
  logic [s_line-1:0] dataout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      dataout_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) dataout_q <= rd_data;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.dataout  = dataout_q;
endmodule

// File: tb/tb_multiway_data_array.sv
// Directed bench for multiway_data_array: reset sweep, byte writes, collisions, flush and async reset.
module tb_multiway_data_array;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multiway_data_array_if #(.s_offset(5), .s_index(3), .s_way(2)) bus ();

  multiway_data_array #(.s_offset(5), .s_index(3), .s_way(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [1:0] way, input logic [2:0] idx);
    bus.rd_req = 1'b1; bus.rd_way = way; bus.rd_index = idx;
    step();
    bus.rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] way, input logic [2:0] idx,
                          input logic [31:0] be, input logic [255:0] d);
    bus.wr_en = be; bus.wr_way = way; bus.wr_index = idx; bus.datain = d;
    step();
    bus.wr_en = '0;
  endtask

  localparam logic [255:0] ZERO   = '0;
  localparam logic [255:0] AA_LO4 = {{28{8'h00}}, {4{8'hAA}}};
  localparam logic [255:0] ALL11  = {32{8'h11}};
  localparam logic [255:0] NEW11  = {{31{8'h11}}, 8'h55};
  localparam logic [255:0] ALL77  = {32{8'h77}};
  localparam logic [255:0] PATA   = {8{32'hDEADBEEF}};

  initial begin
    logic [255:0] exp_coll;
    bus.flush = 0; bus.rd_req = 0; bus.rd_index = 0; bus.rd_way = 0;
    bus.wr_en = '0; bus.wr_index = 0; bus.wr_way = 0; bus.datain = '0;

    // reset held 5 cycles
    repeat (5) step();
    check("rst_ready", 256'(bus.ready), 256'(1'b0));
    check("rst_rd_valid", 256'(bus.rd_valid), 256'(1'b0));
    check("rst_dataout", bus.dataout, ZERO);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("clr_ready_%0d", i), 256'(bus.ready), 256'(i == 8));
    end

    do_read(2'd3, 3'd7);
    check("rd37_valid", 256'(bus.rd_valid), 256'(1'b1));
    check("rd37_data", bus.dataout, ZERO);
    step();
    check("rd37_valid_drop", 256'(bus.rd_valid), 256'(1'b0));

    // byte-enabled write
    do_write(2'd1, 3'd2, 32'h0000_000F, {32{8'hAA}});
    do_read(2'd1, 3'd2);
    check("be_w1s2", bus.dataout, AA_LO4);
    do_read(2'd0, 3'd2);
    check("be_w0s2", bus.dataout, ZERO);
    do_read(2'd1, 3'd3);
    check("be_w1s3", bus.dataout, ZERO);

    // wr_en all zero is not a write
    do_write(2'd1, 3'd3, 32'h0, {32{8'hFF}});
    do_read(2'd1, 3'd3);
    check("noen_w1s3", bus.dataout, ZERO);

    // collision
    do_write(2'd2, 3'd5, 32'hFFFF_FFFF, ALL11);
`ifdef MULTIWAY_DATA_ARRAY_BYPASS_EN
    exp_coll = NEW11;
`else
    exp_coll = ALL11;
`endif
    bus.wr_en = 32'h1; bus.wr_way = 2'd2; bus.wr_index = 3'd5; bus.datain = {32{8'h55}};
    do_read(2'd2, 3'd5);
    bus.wr_en = '0;
    check("coll_valid", 256'(bus.rd_valid), 256'(1'b1));
    check("coll_data", bus.dataout, exp_coll);
    do_read(2'd2, 3'd5);
    check("coll_after", bus.dataout, NEW11);

    // independent read and write in the same cycle
    bus.wr_en = 32'hFFFF_FFFF; bus.wr_way = 2'd0; bus.wr_index = 3'd1; bus.datain = ALL77;
    do_read(2'd1, 3'd2);
    bus.wr_en = '0;
    check("indep_rd", bus.dataout, AA_LO4);
    do_read(2'd0, 3'd1);
    check("indep_wr", bus.dataout, ALL77);

    // back-to-back reads, then hold
    bus.rd_req = 1'b1; bus.rd_way = 2'd1; bus.rd_index = 3'd2;
    step();
    check("b2b_v0", 256'(bus.rd_valid), 256'(1'b1));
    check("b2b_d0", bus.dataout, AA_LO4);
    bus.rd_way = 2'd2; bus.rd_index = 3'd5;
    step();
    check("b2b_v1", 256'(bus.rd_valid), 256'(1'b1));
    check("b2b_d1", bus.dataout, NEW11);
    bus.rd_req = 1'b0;
    step();
    check("hold_v", 256'(bus.rd_valid), 256'(1'b0));
    check("hold_d", bus.dataout, NEW11);

    // flush with simultaneous read and write; traffic held during the sweep is ignored
    bus.flush = 1'b1; bus.rd_req = 1'b1; bus.rd_way = 2'd1; bus.rd_index = 3'd2;
    bus.wr_en = 32'hFFFF_FFFF; bus.wr_way = 2'd3; bus.wr_index = 3'd0; bus.datain = {32{8'hFF}};
    step();
    bus.flush = 1'b0;
    check("fl_valid", 256'(bus.rd_valid), 256'(1'b0));
    check("fl_ready", 256'(bus.ready), 256'(1'b0));
    check("fl_hold_d", bus.dataout, NEW11);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 8) begin bus.rd_req = 1'b0; bus.wr_en = '0; end
      check($sformatf("fl_ready_%0d", i), 256'(bus.ready), 256'(i == 8));
      check($sformatf("fl_valid_%0d", i), 256'(bus.rd_valid), 256'(1'b0));
    end
    do_read(2'd1, 3'd2); check("fl_w1s2", bus.dataout, ZERO);
    do_read(2'd2, 3'd5); check("fl_w2s5", bus.dataout, ZERO);
    do_read(2'd0, 3'd1); check("fl_w0s1", bus.dataout, ZERO);
    do_read(2'd3, 3'd0); check("fl_w3s0", bus.dataout, ZERO);

    // flush restart three cycles after the first pulse
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("rs_ready_0", 256'(bus.ready), 256'(1'b0));
    for (int i = 1; i <= 11; i++) begin
      bus.flush = (i == 3);
      step();
      bus.flush = 1'b0;
      check($sformatf("rs_ready_%0d", i), 256'(bus.ready), 256'(i == 11));
    end

    // async reset while a read result is presented
    do_write(2'd0, 3'd0, 32'hFFFF_FFFF, PATA);
    do_read(2'd0, 3'd0);
    check("ar_pre_valid", 256'(bus.rd_valid), 256'(1'b1));
    check("ar_pre_data", bus.dataout, PATA);
    #2 rst = 1'b0;
    #1;
    check("ar_valid", 256'(bus.rd_valid), 256'(1'b0));
    check("ar_data", bus.dataout, ZERO);
    check("ar_ready", 256'(bus.ready), 256'(1'b0));
    step(); step();
    rst = 1'b1;

    // async reset during cycle 4 of the sweep with a pending read
    step(); step(); step();
    bus.rd_req = 1'b1; bus.rd_way = 2'd0; bus.rd_index = 3'd0;
    #2 rst = 1'b0;
    #1;
    check("ac_valid", 256'(bus.rd_valid), 256'(1'b0));
    check("ac_data", bus.dataout, ZERO);
    check("ac_ready", 256'(bus.ready), 256'(1'b0));
    bus.rd_req = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("ac_clr_ready_%0d", i), 256'(bus.ready), 256'(i == 8));
    end
    do_read(2'd0, 3'd0);
    check("ac_w0s0", bus.dataout, ZERO);
    check("ac_w0s0_v", 256'(bus.rd_valid), 256'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multiway_data_array.md
Name: multiway_data_array

Overview:
- Parametrised, multi-way cache data store: num_ways ways × num_sets sets × s_line-bit lines.
- Per-byte write enables; registered (1-cycle) read of one selected way.
- Built-in sequential clear engine zeroes the whole array after reset and on a flush pulse.
- Sits under the set-associative cache datapath, alongside the tag/valid/LRU arrays.

Parameters:
- s_offset, 5, log2 bytes per line; s_mask = 2**s_offset, s_line = 8*s_mask
- s_index, 3, log2 sets; num_sets = 2**s_index
- s_way, 2, log2 ways; num_ways = 2**s_way

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  one-cycle pulse; starts a full-array clear
- ready  out  1  high when idle and accepting reads/writes
- rd_req  in  1  read request
- rd_index  in  s_index  read set
- rd_way  in  s_way  read way
- wr_en  in  s_mask  per-byte write enable; any bit set = write
- wr_index  in  s_index  write set
- wr_way  in  s_way  write way
- datain  in  s_line  write data
- rd_valid  out  1  pulse: dataout holds the requested line
- dataout  out  s_line  read data

Behaviour:
- Reset (rst=0, async):
  - state=CLEAR, clr_cnt=0, rd_valid=0, dataout=0, ready=0.
  - Array contents are not reset; the CLEAR sweep zeroes them.
- FSM states: IDLE, CLEAR. ready = (state==IDLE), decoded from registered state.
- CLEAR:
  - Each clk edge writes 0 to set clr_cnt in all ways, then clr_cnt++.
  - On the edge that clears set num_sets-1, go to IDLE.
  - ready first high exactly num_sets cycles after rst release.
- Clear priority and dropped requests:
  - flush in IDLE → CLEAR with clr_cnt=0. That cycle's rd_req and wr_en are dropped.
  - flush during CLEAR → clr_cnt restarts at 0.
  - rd_req or wr_en while ready=0: ignored, no rd_valid, no array change.
- Write (IDLE, wr_en≠0): on the clk edge, byte i of line[wr_way][wr_index] ← datain byte i where wr_en[i]=1. Other bytes, ways and sets are unchanged.
- Read (IDLE, rd_req=1):
  - On the edge, dataout ← line[rd_way][rd_index] and rd_valid=1 for that one cycle.
  - Latency 1.
- Back-to-back reads: one per cycle. rd_valid stays high while rd_req stays high.
- No read: dataout holds its last value; rd_valid=0.
- Read/write collision (same cycle, same index and way): result set by MULTIWAY_DATA_ARRAY_BYPASS_EN (see Optional Feature).
- Read/write same cycle, different index or way: independent, no interaction.
- Widths: all indices unsigned. clr_cnt is s_index+1 bits so termination is unambiguous for s_index≥1.

Optional Feature:
- Macro: MULTIWAY_DATA_ARRAY_BYPASS_EN.
- Defined (write-first):
  - On a read/write collision, dataout byte i = datain byte i where wr_en[i]=1, else the old array byte.
  - Registered with the normal 1-cycle latency.
- Undefined (read-first):
  - A collision read returns the pre-write line in full.
  - The write still completes that edge, so the next read sees new data.
- No port differences either way.

Test Plan:
- Reset/clear: hold rst=0 5 cycles, release.
  - ready=0 for 8 cycles, then 1.
  - Read way 3 set 7 → dataout=0, rd_valid one cycle later.
- Byte-enable write:
  - Write wr_en=32'h0000_000F, way 1, set 2, datain=all 0xAA.
  - Read way1/set2 → low 4 bytes 0xAA, rest 0x00.
  - Read way0/set2 → all 0.
- Collision:
  - Preload way2/set5 = all 0x11. Same cycle: write wr_en=32'h1, datain=all 0x55, and read way2/set5.
  - BYPASS_EN: byte0=0x55, bytes1-31=0x11. Without macro: all 0x11.
  - Next read: byte0=0x55.
- Flush mid-traffic:
  - Assert flush with a simultaneous rd_req → no rd_valid; ready low 8 cycles.
  - After ready returns, all previously written lines read 0.
- Flush restart: pulse flush, then again 3 cycles later → ready stays low 3+8=11 cycles after the first pulse.
- Async reset mid-clear and mid-read:
  - Drop rst during cycle 4 of CLEAR with rd_req=1 → rd_valid, dataout, ready go 0 immediately, without a clk edge.
  - Release → full 8-cycle clear again.
